// File: rtl/ebox_store_buffer_if.sv
// ebox_store_buffer_if -- bus between the EBOX, the store buffer and the MBOX.
// Groups the store, drain (req/ack) and load-hazard signals. The master
// modport is the EBOX/MBOX side and the slave modport is the buffer.
// Optional feature macro: EBOX_STBUF_PARITY_EN adds mbParity and injParity.
interface ebox_store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 22
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Store side
    logic              stWrite;
    logic [ADDR_W-1:0] stAddr;
    logic [35:0]       stData;
    logic [1:0]        stHalf;
    logic              stFull;
    logic              stEmpty;
    logic [CNT_W-1:0]  stCount;
    logic              errOverflow;

    // Drain side
    logic              mbReq;
    logic [ADDR_W-1:0] mbAddr;
    logic [35:0]       mbData;
    logic [1:0]        mbHalf;
    logic              mbAck;

    // Load hazard check
    logic              ldCheck;
    logic [ADDR_W-1:0] ldAddr;
    logic              ldHazard;

`ifdef EBOX_STBUF_PARITY_EN
    logic              mbParity;
    logic              injParity;

    modport master (
        output stWrite, stAddr, stData, stHalf, mbAck, ldCheck, ldAddr, injParity,
        input  stFull, stEmpty, stCount, errOverflow,
        input  mbReq, mbAddr, mbData, mbHalf, ldHazard, mbParity
    );

    modport slave (
        input  stWrite, stAddr, stData, stHalf, mbAck, ldCheck, ldAddr, injParity,
        output stFull, stEmpty, stCount, errOverflow,
        output mbReq, mbAddr, mbData, mbHalf, ldHazard, mbParity
    );
`else
    modport master (
        output stWrite, stAddr, stData, stHalf, mbAck, ldCheck, ldAddr,
        input  stFull, stEmpty, stCount, errOverflow,
        input  mbReq, mbAddr, mbData, mbHalf, ldHazard
    );

    modport slave (
        input  stWrite, stAddr, stData, stHalf, mbAck, ldCheck, ldAddr,
        output stFull, stEmpty, stCount, errOverflow,
        output mbReq, mbAddr, mbData, mbHalf, ldHazard
    );
`endif

endinterface

// File: rtl/ebox_store_buffer.sv
// ebox_store_buffer -- posted-write buffer between the EBOX and the MBOX.
// Circular buffer of DEPTH entries drained in order over mbReq/mbAck.
// Back-to-back stores to the newest (non-head) entry's address are merged
// halfword-wise, and ldHazard flags loads that hit any pending entry.
// Data bit numbering: EDP bit 0 (MSB) is vector bit 35, so the left
// halfword (bits 0:17, stHalf[1]) is stData[35:18] and the right halfword
// (bits 18:35, stHalf[0]) is stData[17:0].
// Optional feature macro: EBOX_STBUF_PARITY_EN (stored odd parity per entry).
module ebox_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 22
) (
    input  logic               eboxClk,
    input  logic               eboxReset,
    ebox_store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ebox_store_buffer: DEPTH must be a power of 2 and at least 2");
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [35:0]       data;
        logic [1:0]        half;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [PTR_W-1:0] newest_ptr;
    entry_t           newest;
    entry_t           merged;
    entry_t           pushed;
    logic             is_full;
    logic             st_valid;
    logic             do_merge;
    logic             do_push;
    logic             do_pop;
    logic             hazard;

`ifdef EBOX_STBUF_PARITY_EN
    logic             par_q [DEPTH];
`endif

    // Decode this edge's action: merge into newest, push, drop, and/or pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        newest_ptr = tail_q - PTR_W'(1);
        newest     = mem_q[newest_ptr];
        is_full    = (count_q == CNT_W'(DEPTH));
        st_valid   = bus.stWrite && (bus.stHalf != 2'b00);
        // The head is already on the MBOX bus, so a merge needs a newest entry behind it.
        do_merge   = st_valid && (count_q >= CNT_W'(2)) && (newest.addr == bus.stAddr);
        do_push    = st_valid && !do_merge && !is_full;
        do_pop     = (count_q != '0) && bus.mbAck;

        merged      = newest;
        merged.half = newest.half | bus.stHalf;
        if (bus.stHalf[1]) merged.data[35:18] = bus.stData[35:18];
        if (bus.stHalf[0]) merged.data[17:0]  = bus.stData[17:0];

        pushed = '{addr: bus.stAddr, data: bus.stData, half: bus.stHalf};
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        head_d  = head_q + PTR_W'(do_pop);
        tail_d  = tail_q + PTR_W'(do_push);
        err_d   = err_q | (st_valid && !do_merge && is_full);
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards every entry, including one in flight.
    always_ff @(posedge eboxClk or posedge eboxReset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (eboxReset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry storage: write a new entry at tail or fold a merge into the newest entry.
    always_ff @(posedge eboxClk) begin
        // NOTE: entry contents are not reset; occupancy alone defines validity, so a reset here buys nothing.
        if (do_push) begin
            mem_q[tail_q] <= pushed;
        end else if (do_merge) begin
            mem_q[newest_ptr] <= merged;
        end
    end

`ifdef EBOX_STBUF_PARITY_EN
    // Stored odd parity: computed at push (optionally inverted), recomputed on merge.
    always_ff @(posedge eboxClk) begin
        if (do_push) begin
            par_q[tail_q] <= ~(^bus.stData) ^ bus.injParity;
        end else if (do_merge) begin
            par_q[newest_ptr] <= ~(^merged.data);
        end
    end

    assign bus.mbParity = par_q[head_q];
`endif

    // Load hazard: compare ldAddr against every occupied slot, head included.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(i) - head_q} < count_q && mem_q[i].addr == bus.ldAddr) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.ldHazard    = bus.ldCheck && hazard;
    assign bus.mbReq       = (count_q != '0);
    assign bus.mbAddr      = mem_q[head_q].addr;
    assign bus.mbData      = mem_q[head_q].data;
    assign bus.mbHalf      = mem_q[head_q].half;
    assign bus.stCount     = count_q;
    assign bus.stFull      = (count_q == CNT_W'(DEPTH));
    assign bus.stEmpty     = (count_q == '0);
    assign bus.errOverflow = err_q;

endmodule

// File: tb/tb_ebox_store_buffer.sv
// tb_ebox_store_buffer -- directed scenarios plus randomized traffic against
// a queue-based reference model of the store buffer.
module tb_ebox_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 22;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [35:0]       data;
        logic [1:0]        half;
    } ent_t;

    logic eboxClk;
    logic eboxReset;

    ebox_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    ebox_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .eboxClk   (eboxClk),
        .eboxReset (eboxReset),
        .bus       (bus)
    );

    int   n_vectors     = 0;
    int   n_miscompares = 0;
    ent_t q[$];
    bit   m_err;

    initial eboxClk = 1'b0;
    always #5 eboxClk = ~eboxClk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every observable output against the model for the driven load inputs.
    task automatic compare_all(input bit lc, input logic [ADDR_W-1:0] la);
        bit hz = 1'b0;
        foreach (q[i]) if (q[i].addr == la) hz = 1'b1;
        check("count", 64'(bus.stCount), 64'(q.size()));
        check("full",  64'(bus.stFull),  64'(q.size() == DEPTH));
        check("empty", 64'(bus.stEmpty), 64'(q.size() == 0));
        check("req",   64'(bus.mbReq),   64'(q.size() != 0));
        check("err",   64'(bus.errOverflow), 64'(m_err));
        check("hazard", 64'(bus.ldHazard), 64'(lc && hz));
        if (q.size() != 0) begin
            check("mbAddr", 64'(bus.mbAddr), 64'(q[0].addr));
            check("mbData", 64'(bus.mbData), 64'(q[0].data));
            check("mbHalf", 64'(bus.mbHalf), 64'(q[0].half));
`ifdef EBOX_STBUF_PARITY_EN
            check("mbParity", 64'(bus.mbParity), 64'(~(^q[0].data)));
`endif
        end
    endtask

    // Reference behaviour for one clock edge, decided on pre-edge occupancy.
    task automatic model_edge(input bit st, input logic [ADDR_W-1:0] a, input logic [35:0] d,
                              input logic [1:0] h, input bit ack);
        int   n   = q.size();
        bit   act = st && (h != 2'b00);
        bit   mrg = act && n >= 2 && q[n-1].addr == a;
        bit   pop = (n != 0) && ack;
        ent_t e;
        if (act && !mrg && n == DEPTH) m_err = 1'b1;
        if (mrg) begin
            e = q[n-1];
            if (h[1]) e.data = (e.data & 36'h00003FFFF) | (d & 36'hFFFFC0000);
            if (h[0]) e.data = (e.data & 36'hFFFFC0000) | (d & 36'h00003FFFF);
            e.half = e.half | h;
            q[n-1] = e;
        end
        if (pop) void'(q.pop_front());
        if (act && !mrg && n < DEPTH) begin
            e.addr = a; e.data = d; e.half = h;
            q.push_back(e);
        end
    endtask

    // One cycle: drive inputs while the clock is low, check, clock, update model.
    task automatic step(input bit st, input logic [ADDR_W-1:0] a, input logic [35:0] d,
                        input logic [1:0] h, input bit ack,
                        input bit lc = 1'b0, input logic [ADDR_W-1:0] la = '0);
        bus.stWrite = st;
        bus.stAddr  = a;
        bus.stData  = d;
        bus.stHalf  = h;
        bus.mbAck   = ack;
        bus.ldCheck = lc;
        bus.ldAddr  = la;
        #1;
        compare_all(lc, la);
        @(posedge eboxClk);
        model_edge(st, a, d, h, ack);
        @(negedge eboxClk);
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [35:0] d, input logic [1:0] h);
        step(1'b1, a, d, h, 1'b0);
    endtask

    task automatic idle(input bit ack);
        step(1'b0, '0, '0, 2'b00, ack);
    endtask

    task automatic drain();
        int budget = 16;
        while (q.size() != 0 && budget > 0) begin
            idle(1'b1);
            budget--;
        end
        check("drain_done", 64'(bus.stEmpty), 64'd1);
    endtask

    initial begin
        bus.stWrite = 1'b0; bus.stAddr = '0; bus.stData = '0; bus.stHalf = 2'b00;
        bus.mbAck   = 1'b0; bus.ldCheck = 1'b0; bus.ldAddr = '0;
`ifdef EBOX_STBUF_PARITY_EN
        bus.injParity = 1'b0;
`endif
        m_err     = 1'b0;
        eboxReset = 1'b1;
        #1;
        check("rst_empty", 64'(bus.stEmpty), 64'd1);
        check("rst_full",  64'(bus.stFull),  64'd0);
        check("rst_req",   64'(bus.mbReq),   64'd0);
        check("rst_err",   64'(bus.errOverflow), 64'd0);
        check("rst_count", 64'(bus.stCount), 64'd0);
        repeat (2) @(negedge eboxClk);
        eboxReset = 1'b0;

        // Fill to full, then overflow.
        for (int k = 0; k < 4; k++) push(ADDR_W'(100 + k), 36'(k + 1), 2'b11);
        check("t1_count", 64'(bus.stCount), 64'd4);
        check("t1_full",  64'(bus.stFull),  64'd1);
        check("t1_addr",  64'(bus.mbAddr),  64'd100);
        check("t1_data",  64'(bus.mbData),  64'd1);
        push(ADDR_W'(200), 36'd5, 2'b11);
        check("t1_ovf",   64'(bus.errOverflow), 64'd1);
        check("t1_count2", 64'(bus.stCount), 64'd4);

        // Stall then single ack.
        for (int k = 0; k < 5; k++) begin
            idle(1'b0);
            check("t2_stall_addr", 64'(bus.mbAddr), 64'd100);
            check("t2_stall_data", 64'(bus.mbData), 64'd1);
        end
        idle(1'b1);
        check("t2_addr",  64'(bus.mbAddr),  64'd101);
        check("t2_count", 64'(bus.stCount), 64'd3);
        drain();

        // Halfword merge into the newest entry.
        push(ADDR_W'(10), 36'd0, 2'b11);
        push(ADDR_W'(20), 36'o111111222222, 2'b11);
        push(ADDR_W'(20), 36'o000000333333, 2'b01);
        check("t3_count", 64'(bus.stCount), 64'd2);
        idle(1'b1);
        check("t3_addr", 64'(bus.mbAddr), 64'd20);
        check("t3_data", 64'(bus.mbData), 64'(36'o111111333333));
        check("t3_half", 64'(bus.mbHalf), 64'd3);
        drain();

        // Head is never merged into.
        push(ADDR_W'(30), 36'd7, 2'b11);
        push(ADDR_W'(30), 36'd8, 2'b11);
        check("t4_count", 64'(bus.stCount), 64'd2);
        idle(1'b1);
        check("t4_count2", 64'(bus.stCount), 64'd1);
        check("t4_data",   64'(bus.mbData),  64'd8);
        drain();

        // Load hazards.
        push(ADDR_W'(40), 36'd1, 2'b11);
        push(ADDR_W'(41), 36'd2, 2'b11);
        bus.ldCheck = 1'b1; bus.ldAddr = ADDR_W'(41); #1;
        check("t5_hit41", 64'(bus.ldHazard), 64'd1);
        bus.ldAddr = ADDR_W'(42); #1;
        check("t5_miss42", 64'(bus.ldHazard), 64'd0);
        bus.ldCheck = 1'b0; bus.ldAddr = ADDR_W'(41); #1;
        check("t5_nochk", 64'(bus.ldHazard), 64'd0);
        idle(1'b1);
        idle(1'b1);
        bus.ldCheck = 1'b1; bus.ldAddr = ADDR_W'(41); #1;
        check("t5_drained", 64'(bus.ldHazard), 64'd0);
        bus.ldCheck = 1'b0;

        // Pointer wrap with order preserved.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) push(ADDR_W'(60 + r * 3 + k), 36'($urandom()), 2'b11);
            for (int k = 0; k < 3; k++) idle(1'b1);
        end

        // Mid-stream reset with no clock edge.
        push(ADDR_W'(70), 36'd9, 2'b11);
        push(ADDR_W'(71), 36'd10, 2'b11);
        bus.mbAck = 1'b1;
        eboxReset = 1'b1;
        #1;
        check("t6_empty", 64'(bus.stEmpty), 64'd1);
        check("t6_req",   64'(bus.mbReq),   64'd0);
        check("t6_err",   64'(bus.errOverflow), 64'd0);
        q.delete();
        m_err = 1'b0;
        @(negedge eboxClk);
        eboxReset = 1'b0;

        // Randomized traffic over a small address window.
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 99) < 60),
                 ADDR_W'(500 + $urandom_range(0, 5)),
                 {4'($urandom()), 32'($urandom())},
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 1)),
                 ADDR_W'(500 + $urandom_range(0, 6)));
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/ebox_store_buffer.md
Name: ebox_store_buffer

Overview:
- Posted-write buffer between the EBOX data path and the MBOX.
- Accepts 36-bit store words from the AR, each with a physical address and halfword write enables.
- Drains entries in order to the MBOX over a req/ack handshake.
- Merges back-to-back stores to the same address and reports load/store address hazards so the EBOX can stall reads of pending data.

Parameters:
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.
- ADDR_W, 22: physical address width.

Ports:
- eboxClk  in  1  sole clock; all state updates on its rising edge.
- eboxReset  in  1  asynchronous, active-high reset.
- stWrite  in  1  store request from the EBOX, sampled on the clock edge.
- stAddr  in  ADDR_W  store physical address.
- stData  in  36  store data, bit 0 is the MSB (EDP_AR).
- stHalf  in  2  halfword enables: [1] = bits 0:17, [0] = bits 18:35.
- stFull  out  1  buffer holds DEPTH entries.
- stEmpty  out  1  buffer holds 0 entries.
- stCount  out  $clog2(DEPTH)+1  current occupancy.
- errOverflow  out  1  sticky flag: a store was dropped.
- mbReq  out  1  head entry valid and presented to the MBOX.
- mbAddr  out  ADDR_W  head entry address.
- mbData  out  36  head entry data.
- mbHalf  out  2  head entry halfword enables.
- mbAck  in  1  MBOX accepts the head entry on this edge.
- ldCheck  in  1  EBOX load address qualifier.
- ldAddr  in  ADDR_W  EBOX load physical address.
- ldHazard  out  1  ldAddr matches a pending entry.

Behaviour:
- Reset (asynchronous): head, tail and count go to 0; stEmpty=1; stFull=0; mbReq=0; errOverflow=0; entry contents are don't-care. Reset mid-handshake discards all entries, including the one in flight.
- Storage is a circular buffer with head/tail pointers that wrap modulo DEPTH. stCount holds values 0..DEPTH.
- mbReq = (count != 0). mbAddr, mbData and mbHalf are driven combinationally from the head entry registers and stay stable while mbReq=1 and mbAck=0.
- Pop: when mbReq and mbAck are both 1 at an edge, head advances and count decrements. mbAck while mbReq=0 is ignored.
- Latency: a store accepted at edge N is visible on mbReq/mbAddr after edge N when the buffer was empty. Otherwise it is presented after all older entries pop.
- Merge: when stWrite=1, count>=2 and stAddr equals the newest entry's address:
  - For each stHalf bit set, the corresponding halfword of the newest entry is overwritten with stData.
  - The newest entry's stHalf is ORed with the incoming one.
  - Count is unchanged.
  - A merge is allowed even when the buffer is full.
  - The head entry is never merged into, because it is already presented. With count==1 a same-address store is pushed as a new entry.
- Push: when stWrite=1, no merge applies and the buffer is not full, the entry is written at tail, tail advances and count increments.
- Full: fullness is evaluated before any same-edge pop. A non-merging stWrite while full is dropped and sets errOverflow, which stays set until reset.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- stHalf = 2'b00 store: no effect at all (no push, no merge, no error).
- ldHazard = ldCheck AND (some valid entry, including the head, has addr == ldAddr). It is purely combinational from current state, so it does not yet reflect a same-cycle stWrite.
- stFull = (count == DEPTH); stEmpty = (count == 0).
- No combinational path from stWrite or mbAck to any output except through registers. ldHazard depends combinationally only on ldCheck and ldAddr.

Optional Feature:
- Macro EBOX_STBUF_PARITY_EN.
- When defined:
  - Adds output port mbParity (1 bit): odd parity over the 36 data bits of the head entry.
  - Parity is computed and stored at push and recomputed on merge from the merged word.
  - Adds input injParity (1 bit): when high at push, inverts the stored parity bit, for diagnostics.
- When undefined: neither port exists and no parity storage is generated.

Test Plan:
- Reset then 4 pushes (addr 100,101,102,103; data 1..4; stHalf 11), mbAck=0 -> stFull=1, stCount=4, mbAddr=100, mbData=1. A 5th push (addr 200) -> errOverflow=1, stCount still 4.
- Hold mbReq with mbAck=0 for 5 cycles, then pulse mbAck for 1 cycle -> mbAddr/mbData stable during the stall; after the ack mbAddr=101, stCount=3.
- Push A=10 data 0, then A=20 stHalf 11 data 0o111111222222, then A=20 stHalf 01 data 0o333333 -> stCount=2; the second entry drains as data 0o111111333333 with mbHalf 11.
- Merge exclusion: with a single entry A=30 at head, push A=30 again -> stCount=2; the two entries drain separately.
- Hazard: pending entries 40 and 41; ldCheck=1 with ldAddr=41 -> ldHazard=1; ldAddr=42 -> 0; ldCheck=0 -> 0. After 41 drains, ldAddr=41 -> 0.
- Wrap and reset: 3 pushes, 3 pops (repeated twice to wrap the pointers), data order preserved; assert eboxReset mid-stream -> stEmpty=1, mbReq=0 with no clock edge, errOverflow cleared.
